// File: rtl/text_tilemem_pkg.sv
// Shared constants for the text tile memory: terminal control codes, FSM encoding
// and the shift/add tile address for the 40-column screen.
package text_tilemem_pkg;

    localparam int ADDR_W = 11;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // row*40 + col expressed as (row<<5) + (row<<3) + col, so no multiplier is built
    function automatic logic [ADDR_W-1:0] tile_addr40(input logic [5:0] col, input logic [4:0] row);
        return {1'b0, row, 5'b00000} + {3'b000, row, 3'b000} + {5'b00000, col};
    endfunction

endpackage

// File: rtl/text_tilemem_if.sv
// Byte-stream write channel into the tile memory, plus cursor and sweep status.
interface text_tilemem_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [5:0] cursor_x;
    logic [4:0] cursor_y;
    logic       busy;

    modport master (output wr_valid, wr_data, input wr_ready, cursor_x, cursor_y, busy);
    modport slave  (input wr_valid, wr_data, output wr_ready, cursor_x, cursor_y, busy);
endinterface

// File: rtl/text_tilemem_tile_ram.sv
// Simple dual-port tile RAM: synchronous write, registered read that returns the
// old contents when both ports hit the same address in one cycle.
module tile_ram
    import text_tilemem_pkg::*;
#(
    parameter int DEPTH = 1200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port; the output register carries the only reset so the array stays a plain block RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/text_tilemem.sv
// Text-mode character tile memory: cursor-driven byte writer with control codes,
// clear sweep and a 1-cycle read port. Optional blinking cursor: TEXT_TILEMEM_CURSOR_EN.
module text_tilemem
    import text_tilemem_pkg::*;
#(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 30,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
`ifdef TEXT_TILEMEM_CURSOR_EN
    ,
    parameter logic [7:0] CURSOR_CHAR = 8'h5F,
    parameter int         BLINK_LOG2  = 24
`endif
) (
    input  logic               px_clk,
    input  logic               rst,
    input  logic [5:0]         pos_x,
    input  logic [4:0]         pos_y,
    output logic [7:0]         character,
    text_tilemem_if.slave      wr_bus
);

    localparam logic [5:0]        COL_LAST  = 6'(COLS - 1);
    localparam logic [4:0]        ROW_LAST  = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(COLS * ROWS - 1);

    logic [0:0]        state_r, state_nx_s;
    logic [ADDR_W-1:0] clr_addr_r, clr_addr_nx_s;
    logic [5:0]        cursor_x_r, cx_nx_s;
    logic [4:0]        cursor_y_r, cy_nx_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [7:0]        wdata_s;
    logic              oob_s, oob_r;
    logic [ADDR_W-1:0] raddr_s;
    logic [7:0]        ram_q_s;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [5:0] col, input logic [4:0] row);
        if (COLS == 40) begin
            return tile_addr40(col, row);
        end else begin
            return ADDR_W'(row * COLS) + {5'b00000, col};
        end
    endfunction

    assign wr_bus.wr_ready = (state_r == ST_IDLE);
    assign wr_bus.busy     = (state_r == ST_CLEAR);
    assign wr_bus.cursor_x = cursor_x_r;
    assign wr_bus.cursor_y = cursor_y_r;

    // Next-state, cursor movement and the single RAM write of this cycle.
    always_comb begin
        state_nx_s    = state_r;
        clr_addr_nx_s = clr_addr_r;
        cx_nx_s       = cursor_x_r;
        cy_nx_s       = cursor_y_r;
        we_s          = 1'b0;
        waddr_s       = addr_of(cursor_x_r, cursor_y_r);
        wdata_s       = CLEAR_CHAR;
        case (state_r)
            ST_CLEAR: begin
                we_s    = 1'b1;
                waddr_s = clr_addr_r;
                if (clr_addr_r == ADDR_LAST) begin
                    state_nx_s    = ST_IDLE;
                    clr_addr_nx_s = {ADDR_W{1'b0}};
                end else begin
                    clr_addr_nx_s = clr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                if (wr_bus.wr_valid) begin
                    case (wr_bus.wr_data)
                        CC_LF: begin
                            cx_nx_s = 6'd0;
                            cy_nx_s = (cursor_y_r == ROW_LAST) ? 5'd0 : cursor_y_r + 5'd1;
                        end
                        CC_CR: begin
                            cx_nx_s = 6'd0;
                        end
                        CC_BS: begin
                            if (cursor_x_r != 6'd0) begin
                                cx_nx_s = cursor_x_r - 6'd1;
                            end else if (cursor_y_r != 5'd0) begin
                                cx_nx_s = COL_LAST;
                                cy_nx_s = cursor_y_r - 5'd1;
                            end else begin
                                cx_nx_s = cursor_x_r;
                            end
                            we_s    = 1'b1;
                            waddr_s = addr_of(cx_nx_s, cy_nx_s);
                        end
                        CC_FF: begin
                            cx_nx_s       = 6'd0;
                            cy_nx_s       = 5'd0;
                            state_nx_s    = ST_CLEAR;
                            clr_addr_nx_s = {ADDR_W{1'b0}};
                        end
                        default: begin
                            we_s    = 1'b1;
                            wdata_s = wr_bus.wr_data;
                            if (cursor_x_r == COL_LAST) begin
                                cx_nx_s = 6'd0;
                                cy_nx_s = (cursor_y_r == ROW_LAST) ? 5'd0 : cursor_y_r + 5'd1;
                            end else begin
                                cx_nx_s = cursor_x_r + 6'd1;
                            end
                        end
                    endcase
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                state_nx_s    = ST_CLEAR;
                clr_addr_nx_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // FSM, sweep pointer and cursor registers.
    always_ff @(posedge px_clk) begin
        if (rst) begin
            state_r    <= ST_CLEAR;
            clr_addr_r <= {ADDR_W{1'b0}};
            cursor_x_r <= 6'd0;
            cursor_y_r <= 5'd0;
        end else begin
            state_r    <= state_nx_s;
            clr_addr_r <= clr_addr_nx_s;
            cursor_x_r <= cx_nx_s;
            cursor_y_r <= cy_nx_s;
        end
    end

    // Out-of-range positions read address 0 and are masked to CLEAR_CHAR after the RAM register.
    assign oob_s   = (pos_x > COL_LAST) || (pos_y > ROW_LAST);
    assign raddr_s = oob_s ? {ADDR_W{1'b0}} : addr_of(pos_x, pos_y);

    // Range flag registered alongside the RAM read.
    always_ff @(posedge px_clk) begin
        if (rst) begin
            oob_r <= 1'b0;
        end else begin
            oob_r <= oob_s;
        end
    end

    tile_ram #(
        .DEPTH (COLS * ROWS)
    ) u_ram (
        .clk   (px_clk),
        .rst   (rst),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (raddr_s),
        .rdata (ram_q_s)
    );

`ifdef TEXT_TILEMEM_CURSOR_EN
    logic [BLINK_LOG2-1:0] blink_cnt_r;
    logic                  cur_hit_r;

    // Free-running blink counter.
    always_ff @(posedge px_clk) begin
        if (rst) begin
            blink_cnt_r <= {BLINK_LOG2{1'b0}};
        end else begin
            blink_cnt_r <= blink_cnt_r + {{(BLINK_LOG2-1){1'b0}}, 1'b1};
        end
    end

    // Cursor hit registered in step with the RAM read so latency stays one cycle.
    always_ff @(posedge px_clk) begin
        if (rst) begin
            cur_hit_r <= 1'b0;
        end else begin
            cur_hit_r <= (pos_x == cursor_x_r) && (pos_y == cursor_y_r) && blink_cnt_r[BLINK_LOG2-1];
        end
    end

    assign character = oob_r ? CLEAR_CHAR : (cur_hit_r ? CURSOR_CHAR : ram_q_s);
`else
    assign character = oob_r ? CLEAR_CHAR : ram_q_s;
`endif

endmodule

// File: tb/tb_text_tilemem.sv
// Scoreboard bench for text_tilemem: a reference screen/cursor model predicts every read,
// expectations are queued when a read is driven and compared one clock later.
module tb_text_tilemem;

    logic       px_clk = 1'b0;
    logic       rst;
    logic [5:0] pos_x;
    logic [4:0] pos_y;
    logic [7:0] character;

    text_tilemem_if wr_if();

    always #5 px_clk = ~px_clk;

`ifdef TEXT_TILEMEM_CURSOR_EN
    text_tilemem #(.BLINK_LOG2(4)) dut (
`else
    text_tilemem dut (
`endif
        .px_clk    (px_clk),
        .rst       (rst),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .character (character),
        .wr_bus    (wr_if.slave)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mem_m [1200];
    int         cx_m;
    int         cy_m;
    logic [7:0] exp_q [$];
    string      tag_q [$];

`ifdef TEXT_TILEMEM_CURSOR_EN
    logic [3:0] blink_m;
    always @(posedge px_clk) begin
        if (rst) blink_m <= 4'd0;
        else     blink_m <= blink_m + 4'd1;
    end
`endif

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] model_char(input int x, input int y);
        if (x >= 40 || y >= 30) return 8'h20;
`ifdef TEXT_TILEMEM_CURSOR_EN
        if (x == cx_m && y == cy_m && blink_m[3]) return 8'h5F;
`endif
        return mem_m[y * 40 + x];
    endfunction

    task automatic model_clear();
        foreach (mem_m[i]) mem_m[i] = 8'h20;
        cx_m = 0;
        cy_m = 0;
    endtask

    task automatic model_apply(input logic [7:0] b);
        case (b)
            8'h0A: begin
                cx_m = 0;
                cy_m = (cy_m == 29) ? 0 : cy_m + 1;
            end
            8'h0D: cx_m = 0;
            8'h08: begin
                if (cx_m > 0) cx_m = cx_m - 1;
                else if (cy_m > 0) begin
                    cx_m = 39;
                    cy_m = cy_m - 1;
                end
                mem_m[cy_m * 40 + cx_m] = 8'h20;
            end
            8'h0C: model_clear();
            default: begin
                mem_m[cy_m * 40 + cx_m] = b;
                if (cx_m == 39) begin
                    cx_m = 0;
                    cy_m = (cy_m == 29) ? 0 : cy_m + 1;
                end else begin
                    cx_m = cx_m + 1;
                end
            end
        endcase
    endtask

    // One clock: queue the predicted read, clock, then retire the write into the model and compare.
    task automatic step(input string tag);
        logic       acc;
        logic [7:0] b;
        acc = wr_if.wr_valid && wr_if.wr_ready;
        b   = wr_if.wr_data;
        exp_q.push_back(model_char(int'(pos_x), int'(pos_y)));
        tag_q.push_back(tag);
        @(posedge px_clk);
        #1;
        if (acc) model_apply(b);
        check_val(tag_q.pop_front(), 32'(character), 32'(exp_q.pop_front()));
    endtask

    task automatic send(input logic [7:0] b);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = b;
        step("char_wr");
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic rd(input int x, input int y, input string tag);
        pos_x = 6'(x);
        pos_y = 5'(y);
        step(tag);
    endtask

    task automatic chk_cursor(input string tag);
        check_val({tag, ".cx"}, 32'(wr_if.cursor_x), 32'(cx_m));
        check_val({tag, ".cy"}, 32'(wr_if.cursor_y), 32'(cy_m));
    endtask

    // Called just after rst drops: ready must stay low 1199 cycles and rise after the 1200th edge.
    task automatic sweep_check(input string tag);
        int early;
        early = 0;
        for (int i = 1; i <= 1199; i++) begin
            @(posedge px_clk);
            #1;
            if (wr_if.wr_ready) early++;
        end
        check_val({tag, ".ready_early"}, 32'(early), 32'd0);
        check_val({tag, ".busy@1199"}, 32'(wr_if.busy), 32'd1);
        @(posedge px_clk);
        #1;
        check_val({tag, ".ready@1200"}, 32'(wr_if.wr_ready), 32'd1);
        check_val({tag, ".busy@1200"}, 32'(wr_if.busy), 32'd0);
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst            = 1'b1;
        pos_x          = 6'd0;
        pos_y          = 5'd0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 8'h00;
        model_clear();
        repeat (3) @(posedge px_clk);
        #1;
        check_val("rst.character", 32'(character), 32'h00);
        check_val("rst.wr_ready", 32'(wr_if.wr_ready), 32'd0);
        check_val("rst.busy", 32'(wr_if.busy), 32'd1);
        chk_cursor("rst");
        rst = 1'b0;
        sweep_check("boot");

        rd(0, 0, "boot(0,0)");
        rd(39, 29, "boot(39,29)");
        rd(17, 5, "boot(17,5)");

        send(8'h41);
        send(8'h42);
        chk_cursor("after_AB");
        rd(0, 0, "A(0,0)");
        rd(1, 0, "B(1,0)");
        rd(0, 0, "A_again");
        rd(45, 0, "oob_x");
        rd(0, 30, "oob_y");

        // Same-cell read and write: old data now, new data next read.
        pos_x = 6'd2;
        pos_y = 5'd0;
        send(8'h43);
        rd(2, 0, "collide_new");
        chk_cursor("after_C");

        send(8'h0D);
        for (int i = 0; i < 40; i++) send(8'h61 + 8'(i % 26));
        chk_cursor("row_wrap");
        rd(39, 0, "row_end");

        for (int i = 0; i < 28; i++) send(8'h0A);
        for (int i = 0; i < 39; i++) send(8'h30 + 8'(i % 10));
        chk_cursor("at_39_29");
        send(8'h7E);
        chk_cursor("screen_wrap");
        rd(39, 29, "last_cell");

        for (int i = 0; i < 29; i++) send(8'h0A);
        chk_cursor("lf_to_29");
        send(8'h0A);
        chk_cursor("lf_wrap");

        send(8'h0A);
        send(8'h08);
        chk_cursor("bs_row");
        rd(39, 0, "bs_row_cell");
        send(8'h0D);
        send(8'h08);
        chk_cursor("bs_home");
        rd(0, 0, "bs_home_cell");

        send(8'h58);
        send(8'h59);
        send(8'h0C);
        check_val("ff.ready", 32'(wr_if.wr_ready), 32'd0);
        chk_cursor("ff");
        n = 0;
        while (wr_if.busy && n < 2000) begin
            n++;
            @(posedge px_clk);
            #1;
        end
        check_val("ff.busy_cycles", 32'(n), 32'd1200);
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++)
                rd(x, y, "ff_cell");

        send(8'h5A);
        send(8'h59);
        send(8'h0C);
        repeat (599) @(posedge px_clk);
        #1;
        rst = 1'b1;
        @(posedge px_clk);
        #1;
        rst = 1'b0;
        model_clear();
        chk_cursor("rst600");
        sweep_check("rst600");

        send(8'h51);
        for (int i = 0; i < 32; i++) rd(1, 0, "blink_at");
        for (int i = 0; i < 16; i++) rd(2, 0, "blink_off");
        rd(0, 0, "blink_Q");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/text_tilemem.md
# text_tilemem

Character tile memory for the text-mode VGA path. Holds one 8-bit character code per 8×8 tile of the 40×30 tile screen (320×240 zoomed display). A cursor-driven write port accepts a byte stream with basic terminal control codes. A registered read port, addressed by the current tile column/row, supplies `character` to the `font` stage with the same 1-cycle latency as the sync-delay `register`.

## Interface
Parameters:
- `COLS`, 40: tiles per row.
- `ROWS`, 30: tile rows.
- `CLEAR_CHAR`, 8'h20: fill code for clear.
- `CURSOR_CHAR`, 8'h5F: glyph shown at cursor (only with cursor macro).
- `BLINK_LOG2`, 24: blink counter width; cursor visible while MSB = 1.

Ports:
- `px_clk` in 1: pixel clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pos_x` in 6: tile column of the pixel being fetched, 0..COLS-1.
- `pos_y` in 5: tile row, 0..ROWS-1.
- `character` out 8: code at (`pos_x`,`pos_y`), registered.
- `wr_valid` in 1: byte offered.
- `wr_data` in 8: byte.
- `wr_ready` out 1: block accepts byte this cycle.
- `cursor_x` out 6: current cursor column.
- `cursor_y` out 5: current cursor row.
- `busy` out 1: clear sweep in progress.

## Operation
- Storage: COLS×ROWS×8 simple dual-port RAM, one write and one read per cycle. Address = row*COLS + col, computed with shifts/adds for COLS=40 (row<<5 + row<<3), 11 bits wide.
- FSM states:
  - CLEAR: writes CLEAR_CHAR to address `clr_addr`, incrementing 0..COLS*ROWS-1, then goes to IDLE. `busy`=1, `wr_ready`=0.
  - IDLE: `busy`=0, `wr_ready`=1.
- A byte is accepted on `wr_valid && wr_ready`, fully processed in the same cycle; no backpressure in IDLE.
- 8'h0A (LF): cx←0, cy←cy+1.
- 8'h0D (CR): cx←0.
- 8'h08 (BS): move back one cell and write CLEAR_CHAR there.
  - cx>0: cx−1.
  - cx=0, cy>0: cx←COLS−1, cy−1.
  - At (0,0): stays put, still writes CLEAR_CHAR at (0,0).
- 8'h0C (FF): cursor←(0,0), enter CLEAR.
- Any other code: write the code at (cx,cy), then advance.
  - cx=COLS−1: cx←0, cy+1.
  - cy wraps from ROWS−1 to 0 (no scroll) on advance and on LF.
- Read port: `character` ← RAM[pos]. Out-of-range `pos_x`/`pos_y` return CLEAR_CHAR.

## Timing
- Reset values: `character`=8'h00, `wr_ready`=0, `busy`=1, `cursor_x`=0, `cursor_y`=0, FSM=CLEAR, `clr_addr`=0.
- Clear sweep takes COLS*ROWS = 1200 cycles. The first cycle after `rst` falls writes address 0. `wr_ready` rises in cycle 1201.
- `rst` mid-sweep or mid-stream restarts the sweep from address 0 and homes the cursor.
- Read latency is exactly 1 `px_clk`: `pos_*` at edge N produces `character` valid after edge N+1.
- Read and write to the same address in one cycle: `character` returns the old data. The new data is visible on the next read.
- `cursor_x`/`cursor_y` update on the accepting edge.
- FF takes effect on the next cycle: `wr_ready` is 0 from the cycle after acceptance.

## Configuration
- `TEXT_TILEMEM_CURSOR_EN` defined:
  - A free-running BLINK_LOG2-bit counter runs on `px_clk` and resets to 0.
  - When the read position equals the cursor and the counter MSB = 1, `character` = CURSOR_CHAR instead of RAM data.
  - The compare is registered alongside the RAM read, so latency stays 1.
- Undefined: no counter and no substitution; `character` is always RAM data.

## Structure
- A shared package holds the control-code constants (CC_BS, CC_LF, CC_FF, CC_CR) and the FSM state encoding (ST_CLEAR, ST_IDLE).
- The RAM is one sub-module, `tile_ram` (sync write, sync read, read-old-on-collision), so it infers block RAM.
- Cursor logic, FSM and address arithmetic live in `text_tilemem`.

## Test plan
- Reset then idle:
  - `wr_ready`=0 for 1200 cycles, 1 at cycle 1201.
  - Reading (0,0), (39,29) and (17,5) each returns 8'h20 one cycle later.
- Write 8'h41 ('A') then 8'h42:
  - (0,0)=8'h41, (1,0)=8'h42.
  - Cursor at (2,0).
- Row and screen wrap:
  - 40 bytes from (0,0) put the cursor at (0,1).
  - From (39,29), one write puts the cursor at (0,0).
  - LF at row 29 sets the cursor to (0,0).
- BS:
  - At (0,1): cursor goes to (39,0) and (39,0)=8'h20.
  - At (0,0): cursor stays and (0,0)=8'h20.
- FF after writes:
  - `busy`=1 for 1200 cycles, all cells return 8'h20, cursor at (0,0).
  - Assert `rst` at sweep cycle 600: the sweep restarts and `wr_ready` is still 0 1199 cycles later.
- With `TEXT_TILEMEM_CURSOR_EN` and BLINK_LOG2=4:
  - Reading at the cursor alternates 8'h5F and the RAM value every 8 cycles.
  - Reading one cell off the cursor always returns the RAM value.
